ppu_line_packer: RTL and testbench

//  Downstream of the PPU pixel pipeline: consumes the 2-bit colour-index stream (px_in/px_valid),

---
 rtl/ppu_line_packer.sv | 192 +++++++++++++++++++
 tb/tb_ppu_line_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_packer.sv
// Packs PPU colour indices into 16-bit shade words and queues framebuffer writes.
// Optional FRAME_DOUBLE_BUF_EN: per-word bank bit toggled on each VBLANK entry.
module ppu_line_packer #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        px_in,
    input  logic              px_valid,
    input  logic [1:0]        ppu_mode,
    input  logic [7:0]        bgp,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [15:0]       fb_wr_data,
    input  logic              fb_wr_ready,
    output logic              fb_bank,
    output logic              frame_done,
    output logic              overflow_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef FRAME_DOUBLE_BUF_EN
    localparam int EW = ADDR_W + 17;
`else
    localparam int EW = ADDR_W + 16;
`endif
    localparam logic [7:0]    COL_LAST = 8'(H_PIXELS - 1);
    localparam logic [7:0]    LINE_END = 8'(V_LINES);
    localparam logic [PW:0]   DEPTH_V  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]    M_VBLANK = 2'd1;
    localparam logic [1:0]    M_SCAN   = 2'd2;
    localparam logic [1:0]    M_DRAW   = 2'd3;

    typedef enum logic [1:0] {
        WAIT_DRAW = 2'd0,
        ACTIVE    = 2'd1,
        LINE_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        mode_q;
    logic [7:0]        line;
    logic [7:0]        col;
    logic [2:0]        cnt;
    logic [15:0]       pack;
    logic [ADDR_W-1:0] word_addr;
    logic              out_vld;
    logic [15:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              bank_q;

    logic [1:0] shade;
    logic       draw_start;
    logic       vblank_edge;
    logic       shift_en;
    logic       line_inc;
    logic       enter_active;

    assign shade       = bgp[{px_in, 1'b1} -: 2];
    assign draw_start  = (mode_q == M_SCAN) && (ppu_mode == M_DRAW);
    assign vblank_edge = (mode_q != M_VBLANK) && (ppu_mode == M_VBLANK);

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_DRAW;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        shift_en     = 1'b0;
        line_inc     = 1'b0;
        enter_active = 1'b0;
        unique case (state_q)
            WAIT_DRAW: begin
                if (!vblank_edge && draw_start && line < LINE_END) begin
                    state_d      = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (vblank_edge) begin
                    state_d = WAIT_DRAW;
                end else if (ppu_mode != M_DRAW) begin
                    state_d  = WAIT_DRAW;
                    line_inc = 1'b1;
                end else if (px_valid) begin
                    shift_en = 1'b1;
                    if (col == COL_LAST) state_d = LINE_DONE;
                end
            end
            LINE_DONE: begin
                if (vblank_edge) begin
                    state_d = WAIT_DRAW;
                end else if (ppu_mode != M_DRAW) begin
                    state_d  = WAIT_DRAW;
                    line_inc = 1'b1;
                end
            end
            default: state_d = WAIT_DRAW;
        endcase
    end

    // Completed word is staged one cycle before it enters the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 2'd0;
            line       <= 8'd0;
            col        <= 8'd0;
            cnt        <= 3'd0;
            pack       <= 16'd0;
            word_addr  <= '0;
            out_vld    <= 1'b0;
            out_word   <= 16'd0;
            out_addr   <= '0;
            frame_done <= 1'b0;
            bank_q     <= 1'b0;
        end else begin
            mode_q     <= ppu_mode;
            frame_done <= vblank_edge;
            out_vld    <= shift_en && (cnt == 3'd7);
            if (vblank_edge) begin
                line   <= 8'd0;
                bank_q <= ~bank_q;
            end else if (line_inc && line < LINE_END) begin
                line <= line + 8'd1;
            end
            if (enter_active) begin
                col       <= 8'd0;
                cnt       <= 3'd0;
                word_addr <= ADDR_W'(line) * ADDR_W'(20);
            end
            if (shift_en) begin
                pack <= {pack[13:0], shade};
                col  <= col + 8'd1;
                cnt  <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    out_word  <= {pack[13:0], shade};
                    out_addr  <= word_addr;
                    word_addr <= word_addr + ADDR_W'(1);
                end
            end
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wp, rp;
    logic [EW-1:0] head;
    logic [EW-1:0] entry;
    logic          empty, full, pop, push_ok;

`ifdef FRAME_DOUBLE_BUF_EN
    assign entry = {bank_q, out_addr, out_word};
`else
    assign entry = {out_addr, out_word};
`endif

    assign empty   = (wp == rp);
    assign full    = ((wp - rp) == DEPTH_V);
    assign pop     = !empty && fb_wr_ready;
    assign push_ok = out_vld && (!full || pop);
    assign head    = mem[rp[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[PW-1:0]] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            if (out_vld && full && !pop) overflow_err <= 1'b1;
        end
    end

    assign fb_wr_en   = !empty;
    assign fb_wr_addr = empty ? '0 : head[ADDR_W+15:16];
    assign fb_wr_data = empty ? 16'd0 : head[15:0];
`ifdef FRAME_DOUBLE_BUF_EN
    assign fb_bank = empty ? bank_q : head[EW-1];
`else
    assign fb_bank = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_line_packer.sv
// Directed bench for ppu_line_packer: packing, addressing, back-pressure,
// line/frame sync and reset behaviour.
module tb_ppu_line_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  px_in;
    logic        px_valid;
    logic [1:0]  ppu_mode;
    logic [7:0]  bgp;
    logic        fb_wr_en;
    logic [11:0] fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic        fb_wr_ready;
    logic        fb_bank;
    logic        frame_done;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [31:0] cap_bank[$];

    always #5 clk = ~clk;

    ppu_line_packer dut (
        .clk          (clk),
        .rst          (rst),
        .px_in        (px_in),
        .px_valid     (px_valid),
        .ppu_mode     (ppu_mode),
        .bgp          (bgp),
        .fb_wr_en     (fb_wr_en),
        .fb_wr_addr   (fb_wr_addr),
        .fb_wr_data   (fb_wr_data),
        .fb_wr_ready  (fb_wr_ready),
        .fb_bank      (fb_bank),
        .frame_done   (frame_done),
        .overflow_err (overflow_err)
    );

    always @(negedge clk) begin
        if (!rst && fb_wr_en && fb_wr_ready) begin
            cap_addr.push_back(32'(fb_wr_addr));
            cap_data.push_back(32'(fb_wr_data));
            cap_bank.push_back(32'(fb_bank));
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [1:0] p);
        px_in    = p;
        px_valid = 1'b1;
        tick();
        px_valid = 1'b0;
    endtask

    task automatic start_draw();
        ppu_mode = 2'd2;
        tick();
        ppu_mode = 2'd3;
        tick();
    endtask

    task automatic end_draw();
        ppu_mode = 2'd0;
        tick();
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_bank.delete();
    endtask

    initial begin
        int bad;
        rst         = 1'b1;
        px_in       = 2'd0;
        px_valid    = 1'b0;
        ppu_mode    = 2'd0;
        bgp         = 8'hE4;
        fb_wr_ready = 1'b1;
        tick(3);
        check("rst_wr_en", 32'(fb_wr_en), 0);
        check("rst_addr", 32'(fb_wr_addr), 0);
        check("rst_data", 32'(fb_wr_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow_err), 0);
        check("rst_bank", 32'(fb_bank), 0);
        rst = 1'b0;
        tick();

        // single word on line 0
        start_draw();
        send_px(2'd0); send_px(2'd1); send_px(2'd2); send_px(2'd3);
        send_px(2'd3); send_px(2'd2); send_px(2'd1);
        send_px(2'd0);
        check("lat_not_yet", 32'(fb_wr_en), 0);
        end_draw();
        check("lat_wr_en", 32'(fb_wr_en), 1);
        tick(3);
        check("t1_count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() >= 1) begin
            check("t1_addr", cap_addr[0], 0);
            check("t1_data", cap_data[0], 32'h1BE4);
        end
        clear_cap();

        // early DRAW exit on line 1, then line 2
        start_draw();
        for (int i = 0; i < 13; i++) send_px(2'(i % 4));
        end_draw();
        tick(3);
        bgp = 8'h1B;
        start_draw();
        for (int i = 0; i < 8; i++) send_px(2'd0);
        end_draw();
        tick(3);
        check("t4_count", 32'(cap_addr.size()), 2);
        if (cap_addr.size() >= 2) begin
            check("t4_addr0", cap_addr[0], 20);
            check("t4_data0", cap_data[0], 32'h1B1B);
            check("t4_addr1", cap_addr[1], 40);
            check("t4_data1", cap_data[1], 32'hFFFF);
        end
        clear_cap();
        bgp = 8'hE4;

        // VBLANK entry
        ppu_mode = 2'd1;
        tick();
        check("t5_pulse", 32'(frame_done), 1);
        tick();
        check("t5_pulse_end", 32'(frame_done), 0);
        end_draw();
        start_draw();
        for (int i = 0; i < 8; i++) send_px(2'd2);
        end_draw();
        tick(3);
        check("t5_count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() >= 1) begin
            check("t5_addr", cap_addr[0], 0);
            check("t5_data", cap_data[0], 32'hAAAA);
        end
        clear_cap();

        // full line on line 5 with 4 excess pixels
        ppu_mode = 2'd1;
        tick();
        end_draw();
        for (int l = 0; l < 5; l++) begin
            start_draw();
            end_draw();
        end
        start_draw();
        for (int i = 0; i < 164; i++) send_px(2'(i % 4));
        tick(4);
        end_draw();
        tick(2);
        check("t2_count", 32'(cap_addr.size()), 20);
        bad = 0;
        foreach (cap_addr[i]) begin
            if (cap_addr[i] != 32'(100 + i)) bad++;
            if (cap_data[i] != 32'h1B1B) bad++;
        end
        check("t2_seq", 32'(bad), 0);
        if (cap_addr.size() == 20) begin
            check("t2_first", cap_addr[0], 100);
            check("t2_last", cap_addr[19], 119);
        end
        check("t2_no_ovf", 32'(overflow_err), 0);
        clear_cap();

        // back-pressure on line 6
        fb_wr_ready = 1'b0;
        start_draw();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) send_px(2'(k % 4));
            if (k == 3) begin
                tick(2);
                check("t3_ovf_before", 32'(overflow_err), 0);
            end
        end
        tick(2);
        check("t3_ovf_after", 32'(overflow_err), 1);
        check("t3_wr_en", 32'(fb_wr_en), 1);
        check("t3_head_addr", 32'(fb_wr_addr), 120);
        check("t3_head_data", 32'(fb_wr_data), 32'h0000);
        end_draw();
        fb_wr_ready = 1'b1;
        tick(6);
        check("t3_count", 32'(cap_addr.size()), 4);
        if (cap_addr.size() == 4) begin
            check("t3_a0", cap_addr[0], 120);
            check("t3_a3", cap_addr[3], 123);
            check("t3_d1", cap_data[1], 32'h5555);
            check("t3_d2", cap_data[2], 32'hAAAA);
            check("t3_d3", cap_data[3], 32'hFFFF);
        end
        check("t3_ovf_sticky", 32'(overflow_err), 1);
        clear_cap();

        // reset with 2 entries queued
        fb_wr_ready = 1'b0;
        start_draw();
        for (int i = 0; i < 16; i++) send_px(2'd1);
        tick(2);
        check("t6_pending", 32'(fb_wr_en), 1);
        ppu_mode = 2'd0;
        rst = 1'b1;
        tick();
        check("t6_wr_en", 32'(fb_wr_en), 0);
        check("t6_ovf", 32'(overflow_err), 0);
        rst = 1'b0;
        fb_wr_ready = 1'b1;
        tick();
        start_draw();
        for (int i = 0; i < 8; i++) send_px(2'd3);
        end_draw();
        tick(3);
        check("t6_count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() >= 1) begin
            check("t6_line0", cap_addr[0], 0);
            check("t6_data", cap_data[0], 32'hFFFF);
        end
        clear_cap();

`ifdef FRAME_DOUBLE_BUF_EN
        check("t7_bank0", 32'(fb_bank), 0);
        fb_wr_ready = 1'b0;
        start_draw();
        for (int i = 0; i < 8; i++) send_px(2'd1);
        end_draw();
        tick();
        ppu_mode = 2'd1;
        tick();
        check("t7_head_bank", 32'(fb_bank), 0);
        fb_wr_ready = 1'b1;
        tick(3);
        check("t7_count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() >= 1) check("t7_old_bank", cap_bank[0], 0);
        check("t7_bank1", 32'(fb_bank), 1);
        ppu_mode = 2'd0;
        tick();
        ppu_mode = 2'd1;
        tick();
        check("t7_bank_back", 32'(fb_bank), 0);
        ppu_mode = 2'd0;
        tick();
`else
        ppu_mode = 2'd1;
        tick();
        check("t7_bank_tied", 32'(fb_bank), 0);
        ppu_mode = 2'd0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
